// File: rtl/mag_pkg.sv
// Shared width helpers for the Sobel gradient-magnitude path.
package mag_pkg;

  // Magnitude width after dropping the sign bit and DROP LSBs.
  function automatic int unsigned mag_aw(input int unsigned gw, input int unsigned drop);
    return gw - 32'd1 - drop;
  endfunction

  // Width of one squared magnitude.
  function automatic int unsigned mag_sqw(input int unsigned aw);
    return 32'd2 * aw;
  endfunction

  // Width of the sum of two squares; one carry bit covers the worst case.
  function automatic int unsigned mag_sw(input int unsigned sqw);
    return sqw + 32'd1;
  endfunction

  // Largest representable output pixel code.
  function automatic int unsigned pix_max(input int unsigned pw);
    return (32'd1 << pw) - 32'd1;
  endfunction

endpackage

// File: rtl/mag_quantize.sv
// Maps a sum of squares onto PW-bit pixel bins of STEP sum units each.
module mag_quantize
  import mag_pkg::*;
#(
  parameter int unsigned SW   = 11,
  parameter int unsigned PW   = 4,
  parameter int unsigned STEP = 10
) (
  input  logic [SW-1:0] sum_i,
  output logic [PW-1:0] pixel_o,
  output logic          sat_o
);

  localparam int unsigned PMAX = pix_max(PW);

  logic [31:0] sum_ext;
  assign sum_ext = 32'(sum_i);

  // Comparator chain: the highest multiple of STEP not above sum picks the bin.
  always_comb begin
    pixel_o = '0;
    for (int unsigned k = 1; k <= PMAX; k++) begin
      if (sum_ext >= k * STEP) pixel_o = PW'(k);
    end
    sat_o = (sum_ext >= (PMAX + 32'd1) * STEP);
  end

endmodule

// File: rtl/gradient_magnitude_pipe.sv
// 3-stage elastic gradient-magnitude pipeline: abs/trunc, square, sum/quantise.
// Optional saturation counter enabled by defining MAG_SAT_CNT_EN.
module gradient_magnitude_pipe
  import mag_pkg::*;
#(
  parameter int unsigned GW   = 10,
  parameter int unsigned DROP = 4,
  parameter int unsigned PW   = 4,
  parameter int unsigned STEP = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [GW-1:0] gx,
  input  logic signed [GW-1:0] gy,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        pixel,
  output logic                 out_last
`ifdef MAG_SAT_CNT_EN
  ,
  output logic [15:0]          sat_count
`endif
);

  localparam int unsigned AW  = mag_aw(GW, DROP);
  localparam int unsigned SQW = mag_sqw(AW);
  localparam int unsigned SW  = mag_sw(SQW);

  typedef struct packed {
    logic          last;
    logic [AW-1:0] ax;
    logic [AW-1:0] ay;
  } s1_t;

  typedef struct packed {
    logic           last;
    logic [SQW-1:0] sqx;
    logic [SQW-1:0] sqy;
  } s2_t;

  // |g| with the most negative code clamped, then DROP LSBs discarded.
  function automatic logic [AW-1:0] trunc_abs(input logic [GW-1:0] g);
    logic [GW-1:0] neg;
    logic [GW-2:0] mag;
    neg = ~g + GW'(1);
    if (!g[GW-1])      mag = g[GW-2:0];
    else if (neg[GW-1]) mag = '1;
    else               mag = neg[GW-2:0];
    return AW'(mag >> DROP);
  endfunction

  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t           s1_q, s1_d;
  s2_t           s2_q, s2_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          last_q, last_d;
  logic          sat_q, sat_d;
  logic          rdy1, rdy2, rdy3;
  logic [SW-1:0] sum_c;
  logic [PW-1:0] q_pix;
  logic          q_sat;

  // A stage can load when empty or when the stage after it is moving.
  assign rdy3 = !v3_q || out_ready;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;

  assign in_ready  = rdy1;
  assign out_valid = v3_q;
  assign pixel     = pix_q;
  assign out_last  = last_q;

  assign sum_c = SW'(s2_q.sqx) + SW'(s2_q.sqy);

  mag_quantize #(
    .SW   (SW),
    .PW   (PW),
    .STEP (STEP)
  ) u_quant (
    .sum_i   (sum_c),
    .pixel_o (q_pix),
    .sat_o   (q_sat)
  );

  // Next-state for the three stages; payload only moves with a valid token.
  always_comb begin
    v1_d   = v1_q;
    s1_d   = s1_q;
    v2_d   = v2_q;
    s2_d   = s2_q;
    v3_d   = v3_q;
    pix_d  = pix_q;
    last_d = last_q;
    sat_d  = sat_q;
    if (rdy1) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_d.last = in_last;
        s1_d.ax   = trunc_abs(gx);
        s1_d.ay   = trunc_abs(gy);
      end
    end
    if (rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d.last = s1_q.last;
        s2_d.sqx  = SQW'(s1_q.ax) * SQW'(s1_q.ax);
        s2_d.sqy  = SQW'(s1_q.ay) * SQW'(s1_q.ay);
      end
    end
    if (rdy3) begin
      v3_d = v2_q;
      if (v2_q) begin
        pix_d  = q_pix;
        last_d = s2_q.last;
        sat_d  = q_sat;
      end
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      pix_q  <= '0;
      last_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      pix_q  <= pix_d;
      last_q <= last_d;
      sat_q  <= sat_d;
    end
  end

`ifdef MAG_SAT_CNT_EN
  logic        out_xfer;
  logic [15:0] cnt_q, cnt_d, cnt_incl;

  assign out_xfer = v3_q && out_ready;

  // The frame total must already include the pixel leaving this cycle,
  // so the visible count is the incremented value, cleared after out_last.
  always_comb begin
    cnt_incl = cnt_q;
    if (out_xfer && sat_q && (cnt_q != 16'hFFFF)) cnt_incl = cnt_q + 16'd1;
    cnt_d = cnt_incl;
    if (out_xfer && last_q) cnt_d = '0;
  end

  assign sat_count = cnt_incl;

  // Saturation counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_gradient_magnitude_pipe.sv
// Directed bench for gradient_magnitude_pipe (default parameters).
module tb_gradient_magnitude_pipe;

  localparam int unsigned GW = 10;
  localparam int unsigned PW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, in_last;
  logic                 out_valid, out_ready, out_last;
  logic signed [GW-1:0] gx, gy;
  logic [PW-1:0]        pixel;
`ifdef MAG_SAT_CNT_EN
  logic [15:0]          sat_count;
`endif

  typedef struct {
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic                 last;
    logic [PW-1:0]        pix;
  } vec_t;

  typedef struct {
    logic [PW-1:0] pix;
    logic          last;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   accepted = 0;
  exp_t exp_q[$];
  vec_t vecs[17];

  always #5 clk = ~clk;

  gradient_magnitude_pipe #(
    .GW   (10),
    .DROP (4),
    .PW   (4),
    .STEP (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gx        (gx),
    .gy        (gy),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pixel     (pixel),
    .out_last  (out_last)
`ifdef MAG_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  function automatic vec_t mk(input int x, input int y, input bit last, input int pix);
    vec_t v;
    v.gx   = GW'(x);
    v.gy   = GW'(y);
    v.last = last;
    v.pix  = PW'(pix);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Present one pair and hold it until accepted; records the expected output.
  task automatic send(input vec_t v);
    int n;
    n        = 0;
    gx       = v.gx;
    gy       = v.gy;
    in_last  = v.last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back('{pix: v.pix, last: v.last});
      accepted++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic latency_chk(input string name);
    @(negedge clk); chk({name, "_c1"}, int'(out_valid), 0);
    @(negedge clk); chk({name, "_c2"}, int'(out_valid), 0);
    @(negedge clk); chk({name, "_c3"}, int'(out_valid), 1);
  endtask

  // Scoreboard: every output transfer must match the oldest accepted pair.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", int'(pixel), int'(e.pix));
        chk("out_last", int'(out_last), int'(e.last));
      end
    end
  end

  initial begin
    logic [PW-1:0] held;
    vec_t          fr[4];
    int            n;

    vecs[0]  = mk( 160,    0, 1, 10);
    vecs[1]  = mk(-160,  -64, 0, 11);
    vecs[2]  = mk(  48,    0, 0,  0);
    vecs[3]  = mk(  64,    0, 1,  1);
    vecs[4]  = mk(-512, -512, 0, 15);
    vecs[5]  = mk( 511,    0, 1, 15);
    vecs[6]  = mk(   0,    0, 0,  0);
    vecs[7]  = mk(  79,  -79, 0,  3);
    vecs[8]  = mk( 255,  255, 0, 15);
    vecs[9]  = mk( 100,   50, 1,  4);
    vecs[10] = mk(  -1,  -16, 0,  0);
    vecs[11] = mk( 159,    0, 0,  8);
    vecs[12] = mk( 176, -112, 0, 15);
    vecs[13] = mk( 160,   32, 0, 10);
    vecs[14] = mk( 112,  112, 1,  9);
    vecs[15] = mk( 176,   96, 0, 15);
    vecs[16] = mk( 208,    0, 1, 15);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    gx        = '0;
    gy        = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_out_last", int'(out_last), 0);
`ifdef MAG_SAT_CNT_EN
    chk("rst_sat_count", int'(sat_count), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Single pair latency
    send(vecs[0]);
    latency_chk("latency");
    drain("drain_single");

    // Table sweep at full throughput
    @(posedge clk);
    #1;
    foreach (vecs[i]) send(vecs[i]);
    drain("drain_table");

    // Backpressure: six pairs while the sink stalls for five cycles
    @(posedge clk);
    #1;
    accepted  = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vecs[i]);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_accepted", accepted, 3);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_pixel", int'(pixel), int'(vecs[0].pix));
        held = pixel;
        @(negedge clk);
        chk("stall_pixel_held", int'(pixel), int'(held));
        chk("stall_out_valid_held", int'(out_valid), 1);
      end
    join
    drain("drain_stall");
    chk("stall_total", accepted, 6);

    // Reset with two pairs in flight
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_pixel", int'(pixel), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_flushed", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(vecs[3]);
    latency_chk("post_rst_latency");
    drain("drain_post_rst");

`ifdef MAG_SAT_CNT_EN
    // Frame of four with pairs 2 and 4 saturating
    fr[0] = mk( 160,    0, 0, 10);
    fr[1] = mk(-512, -512, 0, 15);
    fr[2] = mk(  64,    0, 0,  1);
    fr[3] = mk( 208,    0, 1, 15);
    @(posedge clk);
    #1;
    chk("sat_frame_start", int'(sat_count), 0);
    for (int i = 0; i < 4; i++) send(fr[i]);
    n = 0;
    while (!(out_valid && out_last) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sat_last_seen", int'(out_valid && out_last), 1);
    chk("sat_count_at_last", int'(sat_count), 2);
    @(negedge clk);
    chk("sat_count_cleared", int'(sat_count), 0);
    drain("drain_sat");
`else
    fr[0] = vecs[0];
    n     = 0;
    chk("sat_cfg_absent", int'(fr[0].pix) + n, 10);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
